// File: rtl/qspi_pkg.sv
// Shared types and constants for the QSPI flash responder.
package qspi_pkg;

    typedef enum logic [3:0] {
        IDLE,
        CMD,
        ADDR_S,
        ADDR_Q,
        MODE,
        DUMMY,
        DATA_S,
        DATA_Q,
        IGNORE
    } state_e;

    localparam logic [7:0] CMD_READ      = 8'h03;
    localparam logic [7:0] CMD_QREAD     = 8'hEB;
    localparam logic [7:0] CMD_RES       = 8'hAB;

    localparam logic [7:0] CRM_MODE_MASK = 8'hF0;
    localparam logic [7:0] CRM_MODE_VAL  = 8'hA0;

    function automatic logic crm_hit(input logic [7:0] mode);
        return (mode & CRM_MODE_MASK) == CRM_MODE_VAL;
    endfunction

endpackage

// File: rtl/qspi_flash_responder_if.sv
// Flash pins and backing-store port of the QSPI responder.
interface qspi_flash_responder_if #(
    parameter int ADDR_BITS = 24
);
    logic                 flash_clk;
    logic                 flash_csn;
    logic [3:0]           flash_in;
    logic [3:0]           flash_out;
    logic [3:0]           flash_out_en;
    logic [ADDR_BITS-1:0] mem_addr;
    logic                 mem_rd;
    logic [7:0]           mem_data;

    modport master (
        output flash_clk, flash_csn, flash_in, mem_data,
        input  flash_out, flash_out_en, mem_addr, mem_rd
    );

    modport slave (
        input  flash_clk, flash_csn, flash_in, mem_data,
        output flash_out, flash_out_en, mem_addr, mem_rd
    );
endinterface

// File: rtl/qspi_edge_detect.sv
// Two-flop synchronizers for the SPI pins plus SCLK rise/fall and CS fall strobes.
module qspi_edge_detect (
    input  logic       clk_2x,
    input  logic       reset_n,
    input  logic       flash_clk,
    input  logic       flash_csn,
    input  logic [3:0] flash_in,
    output logic       sclk_rise,
    output logic       sclk_fall,
    output logic       csn_fall,
    output logic       csn_high,
    output logic [3:0] din
);
    logic [2:0]       clk_sync_q, clk_sync_d;
    logic [2:0]       csn_sync_q, csn_sync_d;
    logic [1:0][3:0]  in_sync_q, in_sync_d;

    always_comb begin
        clk_sync_d = {clk_sync_q[1:0], flash_clk};
        csn_sync_d = {csn_sync_q[1:0], flash_csn};
        in_sync_d  = {in_sync_q[0], flash_in};
    end

    // CS sync resets low so a CS already held low at reset release is not seen as a fall
    always_ff @(posedge clk_2x or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q <= '0;
            csn_sync_q <= '0;
            in_sync_q  <= '0;
        end else begin
            clk_sync_q <= clk_sync_d;
            csn_sync_q <= csn_sync_d;
            in_sync_q  <= in_sync_d;
        end
    end

    assign sclk_rise = clk_sync_q[1] & ~clk_sync_q[2];
    assign sclk_fall = ~clk_sync_q[1] & clk_sync_q[2];
    assign csn_fall  = ~csn_sync_q[1] & csn_sync_q[2];
    assign csn_high  = csn_sync_q[1];
    assign din       = in_sync_q[1];
endmodule

// File: rtl/qspi_flash_responder.sv
// QSPI flash read responder (0x03 serial, 0xEB quad) backed by an external byte store.
// Define QSPI_RESPONDER_CRM_EN to enable continuous-read mode (mode byte 0xAx).
module qspi_flash_responder
    import qspi_pkg::*;
#(
    parameter int ADDR_BITS    = 24,
    parameter int DUMMY_CLOCKS = 4
) (
    input logic                   clk_2x,
    input logic                   reset_n,
    qspi_flash_responder_if.slave bus
);
    localparam int CW = 8;
    localparam logic [CW-1:0] ADDR_LAST_S = CW'(ADDR_BITS - 1);
    localparam logic [CW-1:0] ADDR_LAST_Q = CW'(ADDR_BITS / 4 - 1);
    localparam logic [CW-1:0] DUMMY_LAST  = CW'(DUMMY_CLOCKS - 1);

    logic       sclk_rise, sclk_fall, csn_fall, csn_high;
    logic [3:0] din;

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [7:0]           shift_q, shift_d;
    logic [7:0]           byte_q, byte_d;
    logic [7:0]           pre_q, pre_d;
    logic                 cap_q, cap_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [ADDR_BITS-1:0] maddr_q, maddr_d;
    logic                 rd_q, rd_d;
    logic [3:0]           out_q, out_d;
    logic [3:0]           en_q, en_d;
    logic                 crm_active;

    qspi_edge_detect u_edge (
        .clk_2x    (clk_2x),
        .reset_n   (reset_n),
        .flash_clk (bus.flash_clk),
        .flash_csn (bus.flash_csn),
        .flash_in  (bus.flash_in),
        .sclk_rise (sclk_rise),
        .sclk_fall (sclk_fall),
        .csn_fall  (csn_fall),
        .csn_high  (csn_high),
        .din       (din)
    );

`ifdef QSPI_RESPONDER_CRM_EN
    logic crm_q, crm_d;
    assign crm_active = crm_q;
    always_ff @(posedge clk_2x or negedge reset_n) begin
        if (!reset_n) crm_q <= 1'b0;
        else          crm_q <= crm_d;
    end
`else
    assign crm_active = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        byte_d  = byte_q;
        // bypass lets the first byte start shifting on the same cycle its read data lands
        pre_d   = cap_q ? bus.mem_data : pre_q;
        cap_d   = rd_q;
        addr_d  = addr_q;
        maddr_d = maddr_q;
        rd_d    = 1'b0;
        out_d   = out_q;
        en_d    = en_q;
`ifdef QSPI_RESPONDER_CRM_EN
        crm_d   = crm_q;
`endif
        if (csn_high) begin
            state_d = IDLE;
            cnt_d   = '0;
            out_d   = '0;
            en_d    = '0;
        end else begin
            unique case (state_q)
                IDLE: if (csn_fall) begin
                    state_d = crm_active ? ADDR_Q : CMD;
                    cnt_d   = '0;
                end
                CMD: if (sclk_rise) begin
                    shift_d = {shift_q[6:0], din[0]};
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == CW'(7)) begin
                        cnt_d = '0;
                        case (shift_d)
                            CMD_READ:  state_d = ADDR_S;
                            CMD_QREAD: state_d = ADDR_Q;
                            CMD_RES:   state_d = IGNORE;
                            default:   state_d = IGNORE;
                        endcase
                    end
                end
                ADDR_S: if (sclk_rise) begin
                    addr_d = {addr_q[ADDR_BITS-2:0], din[0]};
                    cnt_d  = cnt_q + CW'(1);
                    if (cnt_q == ADDR_LAST_S) begin
                        cnt_d   = '0;
                        state_d = DATA_S;
                        rd_d    = 1'b1;
                        maddr_d = addr_d;
                    end
                end
                ADDR_Q: if (sclk_rise) begin
                    addr_d = {addr_q[ADDR_BITS-5:0], din};
                    cnt_d  = cnt_q + CW'(1);
                    if (cnt_q == ADDR_LAST_Q) begin
                        cnt_d   = '0;
                        state_d = MODE;
                        rd_d    = 1'b1;
                        maddr_d = addr_d;
                    end
                end
                MODE: if (sclk_rise) begin
                    shift_d = {shift_q[3:0], din};
                    cnt_d   = cnt_q + CW'(1);
                    if (cnt_q == CW'(1)) begin
                        cnt_d   = '0;
                        state_d = (DUMMY_CLOCKS == 0) ? DATA_Q : DUMMY;
`ifdef QSPI_RESPONDER_CRM_EN
                        crm_d   = crm_hit(shift_d);
`endif
                    end
                end
                DUMMY: if (sclk_rise) begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == DUMMY_LAST) begin
                        cnt_d   = '0;
                        state_d = DATA_Q;
                    end
                end
                DATA_S: if (sclk_fall) begin
                    en_d = 4'b0010;
                    if (cnt_q == '0) begin
                        out_d   = {2'b00, pre_d[7], 1'b0};
                        byte_d  = {pre_d[6:0], 1'b0};
                        addr_d  = addr_q + ADDR_BITS'(1);
                        maddr_d = addr_d;
                        rd_d    = 1'b1;
                    end else begin
                        out_d  = {2'b00, byte_q[7], 1'b0};
                        byte_d = {byte_q[6:0], 1'b0};
                    end
                    cnt_d = (cnt_q == CW'(7)) ? '0 : cnt_q + CW'(1);
                end
                DATA_Q: if (sclk_fall) begin
                    en_d = 4'hF;
                    if (cnt_q == '0) begin
                        out_d   = pre_d[7:4];
                        byte_d  = {pre_d[3:0], 4'h0};
                        addr_d  = addr_q + ADDR_BITS'(1);
                        maddr_d = addr_d;
                        rd_d    = 1'b1;
                        cnt_d   = CW'(1);
                    end else begin
                        out_d = byte_q[7:4];
                        cnt_d = '0;
                    end
                end
                IGNORE: ;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_2x or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            byte_q  <= '0;
            pre_q   <= '0;
            cap_q   <= 1'b0;
            addr_q  <= '0;
            maddr_q <= '0;
            rd_q    <= 1'b0;
            out_q   <= '0;
            en_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            byte_q  <= byte_d;
            pre_q   <= pre_d;
            cap_q   <= cap_d;
            addr_q  <= addr_d;
            maddr_q <= maddr_d;
            rd_q    <= rd_d;
            out_q   <= out_d;
            en_q    <= en_d;
        end
    end

    assign bus.flash_out    = out_q;
    assign bus.flash_out_en = en_q;
    assign bus.mem_addr     = maddr_q;
    assign bus.mem_rd       = rd_q;
endmodule
